// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Round-robin arbiter and sequencer sharing one combinational ALU between two
// requesters. One transaction is in flight at a time: IDLE grants and
// registers the operands, EXEC lets the ALU settle and captures the result,
// and RESP holds the tagged response until the consumer takes it.
module alu_share_arbiter #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_cout,
    output logic              rsp_id,
    output logic [CNT_W-1:0]  op_count
);

    // ADD is the all-ones opcode; it is the only op whose carry is returned
    localparam logic [OP_W-1:0]  OP_ADD  = {OP_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // r_prio names the requester that wins a tie (0 after reset)
    logic r_prio;
    logic w_win_id;
    logic w_grant;
    logic w_rsp_fire;

    // Winner selection: a lone requester always wins, a tie goes to r_prio
    always_comb begin
        w_win_id = 1'b0;
        if (req0_valid && req1_valid) begin
            w_win_id = r_prio;
        end else if (req1_valid) begin
            w_win_id = 1'b1;
        end
    end

    // Next-state and handshake outputs; readys are masked while in reset
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_rsp_fire  = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    w_grant     = 1'b1;
                    req0_ready  = ~w_win_id;
                    req1_ready  = w_win_id;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_rsp_fire  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand/opcode registers feeding the shared ALU, loaded on grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            rsp_id  <= 1'b0;
        end else if (w_grant) begin
            alu_a   <= w_win_id ? req1_a  : req0_a;
            alu_b   <= w_win_id ? req1_b  : req0_b;
            alu_sel <= w_win_id ? req1_op : req0_op;
            rsp_id  <= w_win_id;
        end
    end

    // Result capture at the end of EXEC; carry only survives for ADD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
        end else if (r_state == EXEC) begin
            rsp_result <= alu_result;
            rsp_cout   <= (alu_sel == OP_ADD) ? alu_cout : 1'b0;
        end
    end

    // Completion bookkeeping: saturating count and round-robin pointer flip
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
            r_prio   <= 1'b0;
        end else if (w_rsp_fire) begin
            if (op_count != CNT_MAX) begin
                op_count <= op_count + CNT_W'(1);
            end
            r_prio <= ~rsp_id;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// Directed bench for alu_share_arbiter with a behavioural 4-bit ALU.
// The ALU model drives the raw carry of a+b for every opcode so that carry
// masking of non-ADD results is observable.
module tb_alu_share_arbiter;

    localparam int DATA_W = 4;
    localparam int OP_W   = 2;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst_n;
    logic              req0_valid;
    logic              req0_ready;
    logic [OP_W-1:0]   req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [OP_W-1:0]   req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_sel;
    logic [DATA_W-1:0] alu_result;
    logic              alu_cout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_cout;
    logic              rsp_id;
    logic [CNT_W-1:0]  op_count;

    int n_checks;
    int n_errors;

    alu_share_arbiter #(
        .DATA_W(DATA_W),
        .OP_W  (OP_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_op   (req0_op),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_op   (req1_op),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_result(alu_result),
        .alu_cout  (alu_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU model; carry is the raw a+b carry regardless of opcode
    logic [DATA_W:0] w_sum;
    always_comb begin
        w_sum    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_cout = w_sum[DATA_W];
        case (alu_sel)
            2'b00:   alu_result = alu_a & alu_b;
            2'b01:   alu_result = alu_a | alu_b;
            2'b10:   alu_result = alu_a ^ alu_b;
            default: alu_result = w_sum[DATA_W-1:0];
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One full transaction with rsp_ready high; entered and left at posedge+1 in IDLE
    task automatic run_op(input logic v0, input logic v1, input logic id_e,
                          input logic [3:0] r_e, input logic c_e, input logic [7:0] cnt_e);
        req0_valid = v0;
        req1_valid = v1;
        #1;
        chk("grant_rdy0", req0_ready, !id_e);
        chk("grant_rdy1", req1_ready, id_e);
        @(posedge clk); #1;
        chk("exec_rdy0", req0_ready, 1'b0);
        chk("exec_rdy1", req1_ready, 1'b0);
        chk("exec_vld", rsp_valid, 1'b0);
        chk("exec_a", alu_a, id_e ? req1_a : req0_a);
        chk("exec_b", alu_b, id_e ? req1_b : req0_b);
        chk("exec_sel", alu_sel, id_e ? req1_op : req0_op);
        @(posedge clk); #1;
        chk("resp_vld", rsp_valid, 1'b1);
        chk("resp_result", rsp_result, r_e);
        chk("resp_cout", rsp_cout, c_e);
        chk("resp_id", rsp_id, id_e);
        @(posedge clk); #1;
        chk("done_vld", rsp_valid, 1'b0);
        chk("done_count", op_count, cnt_e);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        req0_op    = 2'b00;
        req0_a     = 4'b0000;
        req0_b     = 4'b0000;
        req1_op    = 2'b00;
        req1_a     = 4'b0000;
        req1_b     = 4'b0000;

        // Reset state, with a request pending that must not be acknowledged
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy0", req0_ready, 1'b0);
        chk("rst_rdy1", req1_ready, 1'b0);
        chk("rst_vld", rsp_valid, 1'b0);
        chk("rst_count", op_count, 8'd0);
        chk("rst_a", alu_a, 4'd0);
        chk("rst_b", alu_b, 4'd0);
        chk("rst_sel", alu_sel, 2'b00);
        chk("rst_result", rsp_result, 4'd0);
        chk("rst_cout", rsp_cout, 1'b0);
        chk("rst_id", rsp_id, 1'b0);
        req0_valid = 1'b0;
        rst_n      = 1'b1;
        @(posedge clk); #1;

        // Single req0 AND 1100 & 1010 = 1000 (raw carry 1 is masked)
        req0_op = 2'b00; req0_a = 4'b1100; req0_b = 4'b1010;
        run_op(1'b1, 1'b0, 1'b0, 4'b1000, 1'b0, 8'd1);

        // req1 ADD 1111 + 0001 = 0000 carry 1, then XOR 1111 ^ 0001 = 1110 carry masked
        req0_valid = 1'b0;
        req1_op = 2'b11; req1_a = 4'b1111; req1_b = 4'b0001;
        run_op(1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 8'd2);
        req1_op = 2'b10;
        run_op(1'b0, 1'b1, 1'b1, 4'b1110, 1'b0, 8'd3);

        // Both valid continuously: grants alternate 0,1,0,1 every 3 cycles
        req0_op = 2'b11; req0_a = 4'b1001; req0_b = 4'b1000;
        req1_op = 2'b01; req1_a = 4'b1001; req1_b = 4'b0110;
        run_op(1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 8'd4);
        run_op(1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 8'd5);
        run_op(1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 8'd6);
        run_op(1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 8'd7);

        // Backpressure: RESP held for 5 cycles, then grant flips to req1
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant_rdy0", req0_ready, 1'b1);
        chk("bp_grant_rdy1", req1_ready, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", rsp_valid, 1'b1);
            chk("bp_result", rsp_result, 4'b0001);
            chk("bp_cout", rsp_cout, 1'b1);
            chk("bp_id", rsp_id, 1'b0);
            chk("bp_rdy0", req0_ready, 1'b0);
            chk("bp_rdy1", req1_ready, 1'b0);
            chk("bp_count", op_count, 8'd7);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_done_count", op_count, 8'd8);
        run_op(1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 8'd9);

        // Reset during EXEC drops the transaction and clears the count
        #1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk("mid_rst_vld", rsp_valid, 1'b0);
        chk("mid_rst_count", op_count, 8'd0);
        chk("mid_rst_a", alu_a, 4'd0);
        @(posedge clk); #1;
        chk("mid_rst_vld2", rsp_valid, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_vld", rsp_valid, 1'b0);
        run_op(1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 8'd1);

        // Saturation: 253 more completions reach 254, then 8 more stick at 255
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (253 * 3) @(posedge clk);
        #1;
        chk("sat_254", op_count, 8'd254);
        repeat (8 * 3 - 1) @(posedge clk);
        #1;
        chk("sat_255", op_count, 8'd255);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_hold", op_count, 8'd255);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
